ifid_skid_reg: RTL and testbench

Parametrised IF/ID pipeline register with a ready/valid handshake on both sides.
- A 2-entry skid buffer absorbs decode back-pressure without losing fetched instructions.
- Synchronous flush squashes wrong-path fetches and presents a NOP to decode.
- Sits between the fetch stage (PC + instruction memory) and the decode stage. It replaces the fixed 64/32-bit IF/ID register in the pipelined core.

---
 rtl/ifid_skid_reg.sv | 128 ++++++++++++
 tb/tb_ifid_skid_reg.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// ---------------------------------------------------------------------------
// ifid_skid_reg
//   IF/ID pipeline register with ready/valid handshakes on both sides.
//   An output stage plus one skid entry give 2 beats of buffering, so decode
//   back-pressure never loses a fetched instruction. in_ready is taken
//   straight from the skid valid flop and never depends on out_ready.
//   flush squashes everything held and leaves a NOP on the decode side.
//
// Optional feature (macro IFID_PERF_CNT_EN):
//   defined   -> saturating stall_cycles / flush_count counters
//   undefined -> the counter ports are tied to 0 and no counter flops exist
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             squash all held beats (branch/jump redirect)
//   in_valid/in_ready fetch-side handshake, carrying pc_in / inst_in
//   out_valid/out_ready decode-side handshake
//   ifid_pc           registered PC of the output beat
//   ifid_pc_inc       registered ifid_pc + PC_INC (mod 2^PC_W)
//   ifid_inst         registered instruction (NOP_INST when output empty)
//   stall_cycles      cycles with out_valid & !out_ready
//   flush_count       cycles with flush asserted
// ---------------------------------------------------------------------------
module ifid_skid_reg #(
  parameter int unsigned          PC_W     = 64,
  parameter int unsigned          INST_W   = 32,
  parameter logic [INST_W-1:0]    NOP_INST = 32'h00000013,
  parameter int unsigned          PC_INC   = 4,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [PC_W-1:0]   ifid_pc_inc,
  output logic [INST_W-1:0] ifid_inst,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  // One buffered beat. pc_inc is formed at capture time so the output
  // stage drives it straight from a flop.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_inc;
    logic [INST_W-1:0] inst;
  } beat_t;

  beat_t out_q, skid_q, in_beat;
  logic  out_valid_q, skid_valid_q;
  logic  in_fire, out_fire, load_out;

  assign in_beat.pc     = pc_in;
  assign in_beat.pc_inc = pc_in + PC_W'(PC_INC);
  assign in_beat.inst   = inst_in;

  // The skid is only ever occupied while the output stage is, so a free
  // skid slot is exactly "one more beat can be absorbed".
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;
  assign load_out = ~out_valid_q | out_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q.pc     <= '0;
      out_q.pc_inc <= '0;
      out_q.inst   <= NOP_INST;
      skid_q       <= '0;
    end else if (flush) begin
      // Any in_fire this cycle is dropped; ifid_pc/pc_inc keep last value.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q.inst   <= NOP_INST;
    end else if (load_out) begin
      if (skid_valid_q) begin
        // Drain: in_ready is low this cycle, so nothing new can arrive.
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q        <= in_beat;
        out_valid_q  <= 1'b1;
      end else begin
        out_valid_q  <= 1'b0;
        out_q.inst   <= NOP_INST;
      end
    end else if (in_fire) begin
      // Output is stalled; park the new beat behind it.
      skid_q       <= in_beat;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign ifid_pc     = out_q.pc;
  assign ifid_pc_inc = out_q.pc_inc;
  assign ifid_inst   = out_q.inst;

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush && flush_q != '1)                     flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Bench for ifid_skid_reg: a directed table of {inputs, expected outputs},
// a counter sequence, then random traffic checked against a queue model.
module tb_ifid_skid_reg;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] pc_in, ifid_pc, ifid_pc_inc;
  logic [31:0] inst_in, ifid_inst, stall_cycles, flush_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifid_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .inst_in(inst_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ifid_pc(ifid_pc), .ifid_pc_inc(ifid_pc_inc), .ifid_inst(ifid_inst),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // ---------------- reference model: FIFO of accepted beats, depth 2 -------
  typedef struct { logic [63:0] pc; logic [31:0] inst; } mbeat_t;
  mbeat_t      mq[$];
  logic [63:0] m_pc, m_inc;

  task automatic model_step(input bit rst, input bit fl, input bit iv,
                            input bit ordy, input logic [63:0] pc,
                            input logic [31:0] inst);
    bit can_take;
    bit has_out;
    mbeat_t b;
    can_take = (mq.size() < 2);
    has_out  = (mq.size() > 0);
    if (rst) begin
      mq.delete(); m_pc = '0; m_inc = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (has_out && ordy) void'(mq.pop_front());
      if (iv && can_take) begin b.pc = pc; b.inst = inst; mq.push_back(b); end
    end
    if (mq.size() > 0) begin m_pc = mq[0].pc; m_inc = mq[0].pc + 64'd4; end
  endtask

  // Drive one cycle's inputs, advance the model, sample after the edge.
  task automatic cycle(input bit rst, input bit fl, input bit iv,
                       input bit ordy, input logic [63:0] pc,
                       input logic [31:0] inst);
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    pc_in = pc; inst_in = inst;
    model_step(rst, fl, iv, ordy, pc, inst);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit rst, fl, iv, ordy;
    logic [63:0] pc; logic [31:0] inst;
    bit e_ov, e_ir;
    logic [63:0] e_pc, e_inc; logic [31:0] e_inst;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(bit rst, bit fl, bit iv, bit ordy,
                             logic [63:0] pc, logic [31:0] inst,
                             bit e_ov, bit e_ir, logic [63:0] e_pc,
                             logic [63:0] e_inc, logic [31:0] e_inst);
    vec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.ordy = ordy; r.pc = pc; r.inst = inst;
    r.e_ov = e_ov; r.e_ir = e_ir; r.e_pc = e_pc; r.e_inc = e_inc; r.e_inst = e_inst;
    return r;
  endfunction

  initial begin
    string nm;
    logic [31:0] exp_stall, exp_flush;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; inst_in = '0;
    mq.delete(); m_pc = '0; m_inc = '0;

    //          rst fl iv or  pc                     inst          ov ir e_pc                   e_inc                  e_inst
    tv.push_back(v(1, 0, 0, 0, 64'h0,                32'h0,        0, 1, 64'h0,                 64'h0,                 NOP));
    // streaming
    tv.push_back(v(0, 0, 1, 1, 64'h1000,             32'hA0000001, 1, 1, 64'h1000,              64'h1004,              32'hA0000001));
    tv.push_back(v(0, 0, 1, 1, 64'h1004,             32'hA0000002, 1, 1, 64'h1004,              64'h1008,              32'hA0000002));
    tv.push_back(v(0, 0, 1, 1, 64'h1008,             32'hA0000003, 1, 1, 64'h1008,              64'h100C,              32'hA0000003));
    tv.push_back(v(0, 0, 0, 1, 64'h0,                32'h0,        0, 1, 64'h1008,              64'h100C,              NOP));
    // back-pressure, skid fill and drain (the 0x2008 offer in the drain cycle is refused)
    tv.push_back(v(0, 0, 1, 0, 64'h2000,             32'hB0000000, 1, 1, 64'h2000,              64'h2004,              32'hB0000000));
    tv.push_back(v(0, 0, 1, 0, 64'h2004,             32'hB0000001, 1, 0, 64'h2000,              64'h2004,              32'hB0000000));
    tv.push_back(v(0, 0, 1, 1, 64'h2008,             32'hB0000009, 1, 1, 64'h2004,              64'h2008,              32'hB0000001));
    tv.push_back(v(0, 0, 0, 1, 64'h0,                32'h0,        0, 1, 64'h2004,              64'h2008,              NOP));
    // refill, then flush with a full skid and a fetch offered
    tv.push_back(v(0, 0, 1, 0, 64'h2010,             32'hB0000002, 1, 1, 64'h2010,              64'h2014,              32'hB0000002));
    tv.push_back(v(0, 0, 1, 0, 64'h2014,             32'hB0000003, 1, 0, 64'h2010,              64'h2014,              32'hB0000002));
    tv.push_back(v(0, 1, 1, 0, 64'h3000,             32'hC0000000, 0, 1, 64'h2010,              64'h2014,              NOP));
    tv.push_back(v(0, 0, 0, 1, 64'h0,                32'h0,        0, 1, 64'h2010,              64'h2014,              NOP));
    // flush while in_ready=1: the accepted fetch is discarded
    tv.push_back(v(0, 1, 1, 1, 64'h3004,             32'hC0000001, 0, 1, 64'h2010,              64'h2014,              NOP));
    // wrap-around
    tv.push_back(v(0, 0, 1, 1, 64'hFFFFFFFFFFFFFFFC, 32'hD0000000, 1, 1, 64'hFFFFFFFFFFFFFFFC,  64'h0,                 32'hD0000000));
    // reset mid-stall with a full skid
    tv.push_back(v(0, 0, 1, 0, 64'h4000,             32'hE0000000, 1, 0, 64'hFFFFFFFFFFFFFFFC,  64'h0,                 32'hD0000000));
    tv.push_back(v(1, 0, 0, 0, 64'h0,                32'h0,        0, 1, 64'h0,                 64'h0,                 NOP));
    tv.push_back(v(0, 0, 0, 1, 64'h0,                32'h0,        0, 1, 64'h0,                 64'h0,                 NOP));

    @(negedge clk);
    foreach (tv[i]) begin
      cycle(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].ordy, tv[i].pc, tv[i].inst);
      nm = $sformatf("vec%0d", i);
      check({nm, "_out_valid"}, 64'(out_valid),   64'(tv[i].e_ov));
      check({nm, "_in_ready"},  64'(in_ready),    64'(tv[i].e_ir));
      check({nm, "_pc"},        ifid_pc,          tv[i].e_pc);
      check({nm, "_pc_inc"},    ifid_pc_inc,      tv[i].e_inc);
      check({nm, "_inst"},      64'(ifid_inst),   64'(tv[i].e_inst));
    end

    // ---------------- performance counters: 5 stalls, 2 flushes ----------
    cycle(0, 0, 1, 0, 64'h5000, 32'hF0000000);        // load, no stall yet
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 64'h0, 32'h0);
    cycle(0, 1, 0, 1, 64'h0, 32'h0);                  // flush + out_fire, no stall
    cycle(0, 1, 0, 0, 64'h0, 32'h0);                  // flush with output empty
`ifdef IFID_PERF_CNT_EN
    exp_stall = 32'd5; exp_flush = 32'd2;
`else
    exp_stall = 32'd0; exp_flush = 32'd0;
`endif
    check("perf_stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    check("perf_flush_count",  64'(flush_count),  64'(exp_flush));
    check("perf_out_valid",    64'(out_valid),    64'(0));

    // ---------------- random traffic vs queue model ----------------------
    cycle(1, 0, 0, 0, 64'h0, 32'h0);
    for (int k = 0; k < 600; k++) begin
      bit          r_rst, r_fl, r_iv, r_or;
      logic [63:0] r_pc;
      logic [31:0] r_inst;
      r_rst  = ($urandom_range(99) < 1);
      r_fl   = ($urandom_range(99) < 5);
      r_iv   = ($urandom_range(99) < 70);
      r_or   = ($urandom_range(99) < 60);
      r_pc   = {$urandom, $urandom};
      r_inst = $urandom;
      cycle(r_rst, r_fl, r_iv, r_or, r_pc, r_inst);
      check("rnd_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      check("rnd_in_ready",  64'(in_ready),  64'(mq.size() < 2));
      check("rnd_pc",        ifid_pc,        m_pc);
      check("rnd_pc_inc",    ifid_pc_inc,    m_inc);
      check("rnd_inst",      64'(ifid_inst), (mq.size() > 0) ? 64'(mq[0].inst) : 64'(NOP));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
